// File: rtl/mux2x1_select_arbiter.sv
// Two-port round-robin arbiter driving the select of a downstream 2x1 mux.
// Define ARB_BURST_LIMIT_EN to cap an owner's grant at BURST cycles while the other port waits.
module mux2x1_select_arbiter #(
    parameter int BURST = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic r0,
    input  logic r1,
    output logic g0,
    output logic g1,
    output logic s,
    output logic v
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [2:0] BURST_LAST = 3'(BURST - 1);
`ifdef ARB_BURST_LIMIT_EN
    localparam logic LIMIT_EN = 1'b1;
`else
    localparam logic LIMIT_EN = 1'b0;
`endif

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [2:0] cnt_q, cnt_d;
    logic       g0_q, g1_q, s_q, s_d, v_q;
    logic       burst_hit_s;

    // Next grant owner; a tie from idle goes to the port that did not win last time.
    always_comb begin
        state_d = state_q;
        // ">=" so an owner that ran past BURST alone still yields once the other port shows up.
        burst_hit_s = LIMIT_EN && (cnt_q >= BURST_LAST);
        case (state_q)
            IDLE: begin
                if (r0 && r1) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (r0) begin
                    state_d = GNT0;
                end else if (r1) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                if (r0 && !(r1 && burst_hit_s)) begin
                    state_d = GNT0;
                end else if (r1) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                if (r1 && !(r0 && burst_hit_s)) begin
                    state_d = GNT1;
                end else if (r0) begin
                    state_d = GNT0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst counter, last-owner flag and mux select derived from the chosen next state.
    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        s_d    = s_q;
        if ((state_d == IDLE) || (state_d != state_q)) begin
            cnt_d = 3'd0;
        end else if (cnt_q != 3'd7) begin
            cnt_d = cnt_q + 3'd1;
        end else begin
            cnt_d = cnt_q;
        end
        case (state_d)
            GNT0: begin
                last_d = 1'b0;
                s_d    = 1'b0;
            end
            GNT1: begin
                last_d = 1'b1;
                s_d    = 1'b1;
            end
            default: begin
                last_d = last_q;
                s_d    = s_q;
            end
        endcase
    end

    // State and registered outputs; reset clears grants at once and lets port 0 win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 3'd0;
            g0_q    <= 1'b0;
            g1_q    <= 1'b0;
            s_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            g0_q    <= (state_d == GNT0);
            g1_q    <= (state_d == GNT1);
            s_q     <= s_d;
            v_q     <= (state_d != IDLE);
        end
    end

    assign g0 = g0_q;
    assign g1 = g1_q;
    assign s  = s_q;
    assign v  = v_q;

endmodule

// File: tb/tb_mux2x1_select_arbiter.sv
// Scoreboard bench for mux2x1_select_arbiter: directed scenarios plus random requests
// checked against a cycle-level grant model.
module tb_mux2x1_select_arbiter;

    localparam int BURST = 4;

    logic clk;
    logic rst_n;
    logic r0, r1;
    logic g0, g1, s, v;

    int n_cmp;
    int n_bad;

    logic [3:0] exp_q[$];

    // Model state: owner -1 = nobody, held = cycles current owner has had the grant.
    int owner_m;
    int last_m;
    int held_m;
    int s_m;

    mux2x1_select_arbiter #(.BURST(BURST)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .r0   (r0),
        .r1   (r1),
        .g0   (g0),
        .g1   (g1),
        .s    (s),
        .v    (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got {g0,g1,s,v}=%b want %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        owner_m = -1;
        last_m  = 1;
        held_m  = 0;
        s_m     = 0;
    endtask

    // Called at a negedge: drive requests, predict the outputs after the next posedge.
    task automatic step(input logic a, input logic b);
        int nxt;
        int req[2];
        bit limit;
        r0 = a;
        r1 = b;
        req[0] = int'(a);
        req[1] = int'(b);
`ifdef ARB_BURST_LIMIT_EN
        limit = 1'b1;
`else
        limit = 1'b0;
`endif
        if (owner_m < 0) begin
            if (a && b)  nxt = (last_m == 1) ? 0 : 1;
            else if (a)  nxt = 0;
            else if (b)  nxt = 1;
            else         nxt = -1;
        end else begin
            int o, x;
            o = owner_m;
            x = 1 - o;
            if (req[o] != 0) nxt = (limit && req[x] != 0 && held_m >= BURST) ? x : o;
            else if (req[x] != 0) nxt = x;
            else nxt = -1;
        end
        if (nxt < 0)            held_m = 0;
        else if (nxt == owner_m) held_m = held_m + 1;
        else                    held_m = 1;
        if (nxt >= 0) begin
            last_m = nxt;
            s_m    = nxt;
        end
        owner_m = nxt;
        exp_q.push_back({(nxt == 0), (nxt == 1), s_m[0], (nxt >= 0)});
        @(negedge clk);
    endtask

    // Monitor: the DUT presents a fresh output every cycle; compare against the oldest prediction.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            check("grant", {g0, g1, s, v}, e);
            if (g0 && g1) begin
                n_cmp++;
                n_bad++;
                $display("FAIL excl: g0=%b g1=%b both high at %0t", g0, g1, $time);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        rst_n = 1'b0;
        r0 = 1'b1;
        r1 = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_hold", {g0, g1, s, v}, 4'b0000);

        // Release with both requesting: port 0 must win the first tie.
        rst_n = 1'b1;
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // Tie round-robin from idle.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            step(1'b0, 1'b0);
        end

        // Handover without an idle bubble.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Idle hold: select stays at 1 after grant 1 drops.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Continuous contention: burst alternation or indefinite hold.
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // Long solo hold then contention.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // Randomised traffic with sticky requests.
        for (int i = 0; i < 400; i++) begin
            logic a, b;
            a = ($urandom_range(0, 3) != 0) ? r0 : 1'($urandom_range(0, 1));
            b = ($urandom_range(0, 3) != 0) ? r1 : 1'($urandom_range(0, 1));
            step(a, b);
        end

        // Async reset between edges while port 1 holds the grant.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        r0 = 1'b0;
        r1 = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("async_reset", {g0, g1, s, v}, 4'b0000);
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("post_reset_idle", {g0, g1, s, v}, 4'b0000);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux2x1_select_arbiter.md
MUX2X1_SELECT_ARBITER -- requirements
Module: mux2x1_select_arbiter

Interface
REQ-001 Parameter: BURST, 4, maximum consecutive grant cycles per owner while the other port is requesting (legal 2..7; used only under REQ-030).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 r0  input  1  request from source feeding mux input a0.
REQ-005 r1  input  1  request from source feeding mux input a1.
REQ-006 g0  output  1  grant to source 0, registered.
REQ-007 g1  output  1  grant to source 1, registered.
REQ-008 s  output  1  select to downstream 2x1 mux (0 = a0, 1 = a1), registered.
REQ-009 v  output  1  downstream data valid, registered; equals g0 | g1.

Function
REQ-010 FSM states: IDLE, GNT0, GNT1; g0 = (state==GNT0), g1 = (state==GNT1).
REQ-011 Internal flag last: owner of the most recent grant (0/1); updated on entry to GNT0/GNT1.
REQ-012 Latency: request sampled at edge N produces grant visible after edge N (one cycle from request assertion to grant).
REQ-013 IDLE: r0 only -> GNT0; r1 only -> GNT1; both -> grant the port != last; neither -> stay IDLE.
REQ-014 GNT0: r0 high -> stay (subject to REQ-030); r0 low and r1 high -> GNT1 directly, no IDLE bubble; both low -> IDLE.
REQ-015 GNT1: symmetric to REQ-014 with ports swapped.
REQ-016 s = 0 in GNT0, 1 in GNT1; in IDLE s holds its previous value (no spurious toggle).
REQ-017 g0 and g1 never high simultaneously in any cycle, including reset exit.
REQ-018 Burst counter cnt, 3 bits: cleared on every grant change or entry from IDLE, increments each cycle grant is held, saturates at 7 (no wrap).
REQ-019 Request deassertion mid-grant takes effect at the next edge; grant drops one cycle after request drops.
REQ-020 Requests are level-sensitive; no latching of pulses shorter than one cycle.

Reset
REQ-021 rst_n low asynchronously forces state=IDLE, g0=0, g1=0, v=0, s=0, cnt=0, last=1 (port 0 wins first tie).
REQ-022 Reset asserted mid-grant clears outputs immediately, without waiting for clk.
REQ-023 First grant after rst_n release follows REQ-012 from the first edge with rst_n high.

Configuration
REQ-030 Macro ARB_BURST_LIMIT_EN defined: when owner has held grant BURST cycles (cnt == BURST-1 at the edge) and the other port requests, switch directly to the other grant state; if other port idle, owner keeps grant.
REQ-031 ARB_BURST_LIMIT_EN undefined: owner keeps grant until its request drops; cnt logic may be removed; parameter BURST ignored.

Verification
REQ-040 Reset: rst_n=0 with r0=r1=1 -> g0=g1=v=s=0; release -> after first edge g0=1, s=0, v=1.
REQ-041 Tie round-robin: r0=r1=1 pulsed one cycle each from IDLE, three times -> grants alternate 0,1,0; s follows 0,1,0.
REQ-042 Handover: r0=1 held 3 cycles, r1 rises in cycle 2 and stays, r0 drops -> g0 for 3 cycles then g1 on next edge, v never drops.
REQ-043 Burst limit (ARB_BURST_LIMIT_EN, BURST=4): r0=r1=1 continuously -> g0 4 cycles, g1 4 cycles, repeating; without macro -> g0 held indefinitely.
REQ-044 Idle hold: GNT1 then both requests drop -> v=0, g1=0, s stays 1 until next grant.
REQ-045 Async reset mid-grant: rst_n pulsed low between edges during GNT1 -> g1, v, s go 0 immediately; last=1 so next tie grants port 0.
